// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default reset PC, fetch FSM states and
// the opcodes used by the decoder and immediate generator.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry {pc, instr} holding register used while decode is stalled.
// Clear takes priority over load.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word fetches, presents IF/ID outputs, parks a
// returned word in a skid buffer under stall. FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect trap.
//
//   state | meaning
//   IDLE  | one cycle after reset before the first request
//   REQ   | imem_req asserted at pc, waiting for imem_ready
//   HOLD  | word parked in skid buffer until stall drops
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         err_q, err_d;

  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  fetch_skid_buffer u_skid (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    err_d      = err_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (branch_taken) begin
      // Redirect beats stall and any same-cycle response; flush always applies.
      state_d    = REQ;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      skid_clear = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (branch_target[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else begin
        pc_d = branch_target;
      end
`else
      pc_d = branch_target & 32'hFFFF_FFFC;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ready) begin
            if (!stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = imem_rdata;
              pc_d       = pc_next(pc_q);
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc;
            if_instr_d = skid_instr;
            pc_d       = pc_next(pc_q);
            skid_clear = 1'b1;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req       = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign fetch_err      = err_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 Port: imem_ready  input  1  imem_rdata valid this cycle for current imem_addr; ignored when imem_req=0.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: stall  input  1  downstream (decode/immediate generation) cannot accept; IF/ID outputs hold.
REQ-009 Port: branch_taken  input  1  redirect request from execute (BEQ resolved taken).
REQ-010 Port: branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-011 Port: if_valid  output  1  if_instruction/if_pc hold a live instruction.
REQ-012 Port: if_pc  output  32  address of if_instruction.
REQ-013 Port: if_instruction  output  32  instruction word for decoder and immediate generator.
REQ-014 Port: fetch_err  output  1  sticky misaligned-redirect flag.

Function
REQ-015 States SHALL be IDLE, REQ, HOLD; reset enters IDLE; IDLE -> REQ unconditionally next cycle.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal internal pc; IDLE/HOLD drive imem_req=0.
REQ-017 REQ with imem_ready=1, stall=0: if_instruction<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), remain REQ.
REQ-018 REQ with imem_ready=1, stall=1: word and pc captured in skid buffer, state -> HOLD, IF/ID outputs unchanged.
REQ-019 HOLD with stall=0: skid buffer -> IF/ID outputs, if_valid<=1, pc<=pc+4, state -> REQ; HOLD with stall=1: no change.
REQ-020 REQ with imem_ready=0, stall=0: if_valid<=0, if_instruction<=32'h0000_0013 (NOP); stall=1: outputs hold.
REQ-021 Latency: instruction SHALL appear on if_instruction exactly one cycle after the edge at which imem_ready=1 is sampled (absent stall/branch).
REQ-022 branch_taken=1 SHALL win over stall and imem_ready in the same cycle: next cycle pc=branch_target, if_valid=0, if_instruction=NOP, skid buffer emptied, same-cycle response discarded, state REQ.
REQ-023 Redirect while in HOLD SHALL drop the held word; redirect in IDLE SHALL take effect on the IDLE -> REQ transition.
REQ-024 imem_req/imem_addr MAY change any cycle; imem_ready qualifies only the current cycle's address.

Reset
REQ-025 rst_n=0 at an edge: state IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instruction=NOP, skid buffer empty, fetch_err=0; overrides branch_taken and any in-flight response.

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN defined: branch_target[1:0]!=0 ignores the redirect (flush still applied, pc unchanged) and sets fetch_err=1 until reset.
REQ-027 Macro undefined: branch_target[1:0] forced to 2'b00 on redirect; fetch_err tied 0.

Structure
REQ-028 Shared package cpu_pkg SHALL hold NOP_INSTR (32'h0000_0013), default RESET_PC, fetch-state enum, opcode constants (LW 0000011, SW 0100011, ADDI 0010011, BEQ 1100011).
REQ-029 One sub-module fetch_skid_buffer (single-entry {pc, instr} register with load/clear/valid) SHALL be instantiated; FSM and pc logic remain in instruction_fetch.

Verification
REQ-030 Reset, RESET_PC=0, imem_ready=1 always, stall=0 -> if_pc 0,4,8,... on consecutive cycles, if_valid=1 from 3rd cycle after reset release.
REQ-031 imem_ready=0 for 3 cycles at addr 0x10 -> if_valid=0, if_instruction=0x00000013 for those cycles, imem_addr holds 0x10.
REQ-032 stall=1 coincident with ready at addr 0x20 for 4 cycles -> outputs hold prior word, imem_req=0; stall release -> if_pc=0x20 next cycle, then 0x24.
REQ-033 branch_taken=1, target 0x100, with stall=1 and imem_ready=1 same cycle -> next cycle if_valid=0, imem_addr=0x100; old word never appears.
REQ-034 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-035 With FETCH_MISALIGN_CHECK_EN, target 0x102 -> fetch_err=1 sticky, imem_addr continues from unredirected pc; without macro -> imem_addr=0x100, fetch_err=0.
